multicycle_control: RTL

Multicycle sequencer for the MIPS datapath. It replaces the single-cycle combinational `Control` decode with a Moore state machine that walks each instruction through fetch, decode, execute, memory and writeback steps. It drives the mux selects and write enables of a shared-memory datapath (PC, IR, register file, ALU, unified memory) and stalls on a memory-ready handshake. Opcode and funct come from the instruction register.

---
 rtl/multicycle_control.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Moore sequencer for a multicycle MIPS datapath: walks each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath selects and enables.
module multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_JAL   = 6'b000011,
    parameter logic [5:0] FUNCT_JR = 6'b001000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXEC      = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_JUMP      = 4'd12,
        S_JAL       = 4'd13,
        S_JR        = 4'd14,
        S_ILLEGAL   = 4'd15
    } state_e;

    state_e state_q, state_d;
    // Opcode is only valid to sample at the DECODE edge, so remember LW vs SW here.
    logic   is_lw_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the same pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            is_lw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                is_lw_q <= (opcode == OP_LW);
            end
        end
    end

    // NOTE: state_d gets its default before the case so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      state_d = S_FETCH;
            S_FETCH:     if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW) begin
                    state_d = S_MEM_ADDR;
                end else if (opcode == OP_RTYPE) begin
                    state_d = (funct == FUNCT_JR) ? S_JR : S_EXEC;
                end else if (opcode == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else if (opcode == OP_ADDI) begin
                    state_d = S_ADDI_EX;
                end else if (opcode == OP_J) begin
                    state_d = S_JUMP;
                end else if (opcode == OP_JAL) begin
                    state_d = S_JAL;
                end else begin
                    state_d = S_ILLEGAL;
                end
            end
            S_MEM_ADDR:  state_d = is_lw_q ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
            S_EXEC:      state_d = S_R_WB;
            S_ADDI_EX:   state_d = S_ADDI_WB;
            S_ILLEGAL:   state_d = S_ILLEGAL;
            default:     state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        reg_dst       = 2'b00;
        mem_to_reg    = 2'b00;
        pc_source     = 2'b00;
        instr_done    = 1'b0;
        illegal       = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE:    alu_src_b = 2'b11;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 2'b01;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                instr_done = 1'b1;
            end
            S_JR: begin
                pc_write   = 1'b1;
                pc_source  = 2'b11;
                instr_done = 1'b1;
            end
            S_ILLEGAL:   illegal = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

endmodule
